// File: rtl/sum_bcd_conv.sv
// sum_bcd_conv: converts an 8-bit two's-complement sum to sign plus three BCD digits
// using an 8-step shift-and-add-3 sequence triggered by a rising edge on start.
module sum_bcd_conv (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] sum_in,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    state_t      state, state_n;
    logic        start_q, trig, neg_r;
    logic [7:0]  mag;
    logic [11:0] scr, adj;
    logic [2:0]  cnt;
    assign trig = start & ~start_q;
    always_comb begin
        adj[3:0]   = (scr[3:0]   >= 4'd5) ? scr[3:0]   + 4'd3 : scr[3:0];
        adj[7:4]   = (scr[7:4]   >= 4'd5) ? scr[7:4]   + 4'd3 : scr[7:4];
        adj[11:8]  = (scr[11:8]  >= 4'd5) ? scr[11:8]  + 4'd3 : scr[11:8];
    end
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && trig)         ? SHIFT  :
                  (state == SHIFT && cnt == 3'd7) ? FINISH :
                  (state == FINISH)               ? IDLE   : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            neg      <= 1'b0;
            neg_r    <= 1'b0;
            mag      <= 8'd0;
            scr      <= 12'd0;
            cnt      <= 3'd0;
            bcd_hund <= 4'd0;
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
        end else begin
            start_q <= start;
            state   <= state_n;
            done    <= 1'b0;
            if (state == IDLE && trig) begin
                neg_r <= sum_in[7];
                mag   <= sum_in[7] ? ~sum_in + 8'd1 : sum_in;
                scr   <= 12'd0;
                cnt   <= 3'd0;
                busy  <= 1'b1;
            end
            if (state == SHIFT) begin
                {scr, mag} <= {adj[10:0], mag, 1'b0};
                cnt        <= cnt + 3'd1;
            end
            if (state == FINISH) begin
                {bcd_hund, bcd_tens, bcd_ones} <= scr;
                neg  <= neg_r;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sum_bcd_conv.sv
// tb_sum_bcd_conv: randomized and directed checks of sum_bcd_conv against an
// arithmetic model (abs value split into decimal digits).
module tb_sum_bcd_conv;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] sum_in = 8'd0;
    logic       busy, done, neg;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;
    int         checks = 0, failures = 0;

    sum_bcd_conv dut (
        .clk(clk), .rst(rst), .start(start), .sum_in(sum_in),
        .busy(busy), .done(done), .neg(neg),
        .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] model(input logic [7:0] v);
        int m;
        m = v[7] ? 256 - int'(v) : int'(v);
        return {v[7], 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [12:0] outs();
        return {neg, bcd_hund, bcd_tens, bcd_ones};
    endfunction

    // Raises start at the current negedge, drops it one cycle later and waits for done.
    task automatic run_conv(input logic [7:0] v, output int lat, output bit busy_ok, output bit stable);
        logic [12:0] snap;
        snap    = outs();
        sum_in  = v;
        start   = 1'b1;
        lat     = -1;
        busy_ok = 1'b1;
        stable  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
                lat = i - 1;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (outs() != snap) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, outs()} !== 15'd0) begin
            failures++;
            $display("FAIL reset: got %h expected 0", {busy, done, outs()});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] vals [5] = '{8'h0E, 8'hF0, 8'h7F, 8'h80, 8'h00};
        int lat;
        bit bok, stb;
        foreach (vals[k]) begin
            run_conv(vals[k], lat, bok, stb);
            checks++;
            if (lat !== 9) begin
                failures++;
                $display("FAIL latency %h: got %0d expected 9", vals[k], lat);
            end
            checks++;
            if (outs() !== model(vals[k])) begin
                failures++;
                $display("FAIL result %h: got %h expected %h", vals[k], outs(), model(vals[k]));
            end
            checks++;
            if (!bok || !stb) begin
                failures++;
                $display("FAIL busy/stable %h: got busy_ok=%0b stable=%0b expected 1 1", vals[k], bok, stb);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse %h: got %b expected 0", vals[k], done);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        int lat;
        bit bok, stb;
        for (int n = 0; n < 25; n++) begin
            v = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_conv(v, lat, bok, stb);
            checks++;
            if (lat !== 9 || outs() !== model(v) || !bok || !stb) begin
                failures++;
                $display("FAIL random %h: got lat=%0d out=%h busy_ok=%0b stable=%0b expected lat=9 out=%h 1 1",
                         v, lat, outs(), bok, stb, model(v));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_start();
        int dones = 0;
        @(negedge clk);
        sum_in = 8'hD3;
        start  = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i == 3) begin
                start  = 1'b0;
                sum_in = 8'h25;
            end
            if (i == 4) start = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL hold_start_dones: got %0d expected 1", dones);
        end
        checks++;
        if (outs() !== model(8'hD3)) begin
            failures++;
            $display("FAIL hold_start_result: got %h expected %h", outs(), model(8'hD3));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, dones = 0;
        bit bok, stb;
        sum_in = 8'h63;
        start  = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        checks++;
        if ({busy, done, outs()} !== 15'd0) begin
            failures++;
            $display("FAIL reset_mid: got %h expected 0", {busy, done, outs()});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_nodone: got %0d expected 0", dones);
        end
        run_conv(8'h9C, lat, bok, stb);
        checks++;
        if (lat !== 9 || outs() !== model(8'h9C)) begin
            failures++;
            $display("FAIL reset_mid_next: got lat=%0d out=%h expected lat=9 out=%h", lat, outs(), model(8'h9C));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        bit bok, stb;
        run_conv(8'h41, lat1, bok, stb);
        run_conv(8'hB5, lat2, bok, stb);
        checks++;
        if (lat1 !== 9 || lat2 !== 9) begin
            failures++;
            $display("FAIL back_to_back_latency: got %0d,%0d expected 9,9", lat1, lat2);
        end
        checks++;
        if (outs() !== model(8'hB5) || !bok || !stb) begin
            failures++;
            $display("FAIL back_to_back_result: got %h expected %h", outs(), model(8'hB5));
        end
        @(negedge clk);
    endtask

    task automatic test_release_start_high();
        int dones = 0;
        rst    = 1'b1;
        start  = 1'b1;
        sum_in = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || outs() !== model(8'hFF)) begin
            failures++;
            $display("FAIL release_start_high: got dones=%0d out=%h expected 1 %h", dones, outs(), model(8'hFF));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        test_release_start_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
